// File: rtl/dcout_seq.sv
// Output-stage sequencer for the binary-convolutional decoder: walks a zero-padded
// frame into the window shift register and sweeps every class filter per output pixel.
module dcout_seq #(
   parameter int H      = 32,
   parameter int W      = 128,
   parameter int FH     = 3,
   parameter int FW     = 3,
   parameter int PAD    = 1,
   parameter int FD     = 512,
   parameter int ADDR_W = (FD > 1) ? $clog2(FD) : 1,
   parameter int ROW_W  = (H > 1) ? $clog2(H) : 1,
   parameter int COL_W  = (W > 1) ? $clog2(W) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              in_en,
   output logic              in_ready,
   output logic              sr_en,
   output logic              pad_sel,
   output logic              rom_en,
   output logic [ADDR_W-1:0] rom_addr,
   output logic              out_en,
   output logic [ROW_W-1:0]  out_row,
   output logic [COL_W-1:0]  out_col,
   output logic [ADDR_W-1:0] out_cls,
   output logic              busy,
   output logic              done
);

   localparam int HP = H + 2 * PAD;
   localparam int WP = W + 2 * PAD;
   localparam int RW = (HP > 1) ? $clog2(HP) : 1;
   localparam int CW = (WP > 1) ? $clog2(WP) : 1;

   typedef enum logic [2:0] {IDLE, FEED, COMPUTE, FLUSH, DONE} state_t;

   state_t              state_reg, state_next;
   logic [RW-1:0]       r_reg, r_next;
   logic [CW-1:0]       c_reg, c_next;
   logic [ADDR_W-1:0]   k_reg, k_next;
   logic [ROW_W-1:0]    tag_row_reg, tag_row_next;
   logic [COL_W-1:0]    tag_col_reg, tag_col_next;
   logic                out_en_reg;
   logic [ROW_W-1:0]    out_row_reg;
   logic [COL_W-1:0]    out_col_reg;
   logic [ADDR_W-1:0]   out_cls_reg;

   logic                is_pad, at_window, at_last, feed_shift;
   logic [RW-1:0]       r_adv;
   logic [CW-1:0]       c_adv;

   always_comb begin
      is_pad     = (int'(r_reg) < PAD) || (int'(r_reg) >= H + PAD) ||
                   (int'(c_reg) < PAD) || (int'(c_reg) >= W + PAD);
      at_window  = (int'(r_reg) >= FH - 1) && (int'(c_reg) >= FW - 1);
      at_last    = (int'(r_reg) == HP - 1) && (int'(c_reg) == WP - 1);
      feed_shift = is_pad || in_en;
      if (int'(c_reg) == WP - 1) begin
         c_adv = '0;
         r_adv = r_reg + RW'(1);
      end else begin
         c_adv = c_reg + CW'(1);
         r_adv = r_reg;
      end
   end

   always_comb begin
      state_next   = state_reg;
      r_next       = r_reg;
      c_next       = c_reg;
      k_next       = k_reg;
      tag_row_next = tag_row_reg;
      tag_col_next = tag_col_reg;
      in_ready     = 1'b0;
      sr_en        = 1'b0;
      pad_sel      = 1'b0;
      rom_en       = 1'b0;
      rom_addr     = '0;
      busy         = 1'b1;
      done         = 1'b0;
      case (state_reg)
         IDLE: begin
            busy = 1'b0;
            if (start) begin
               state_next = FEED;
               r_next     = '0;
               c_next     = '0;
            end
         end
         FEED: begin
            pad_sel  = is_pad;
            in_ready = !is_pad;
            sr_en    = feed_shift;
            if (feed_shift) begin
               // A full window is in the shift register once the bottom-right tap lands.
               if (at_window) begin
                  state_next   = COMPUTE;
                  k_next       = '0;
                  tag_row_next = ROW_W'(int'(r_reg) - (FH - 1));
                  tag_col_next = COL_W'(int'(c_reg) - (FW - 1));
               end else begin
                  r_next = r_adv;
                  c_next = c_adv;
               end
            end
         end
         COMPUTE: begin
            rom_en   = 1'b1;
            rom_addr = k_reg;
            k_next   = k_reg + ADDR_W'(1);
            if (int'(k_reg) == FD - 1) begin
               k_next = '0;
               if (at_last) begin
                  state_next = FLUSH;
               end else begin
                  state_next = FEED;
                  r_next     = r_adv;
                  c_next     = c_adv;
               end
            end
         end
         FLUSH: state_next = DONE;
         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg   <= IDLE;
         r_reg       <= '0;
         c_reg       <= '0;
         k_reg       <= '0;
         tag_row_reg <= '0;
         tag_col_reg <= '0;
         out_en_reg  <= 1'b0;
         out_row_reg <= '0;
         out_col_reg <= '0;
         out_cls_reg <= '0;
      end else begin
         state_reg   <= state_next;
         r_reg       <= r_next;
         c_reg       <= c_next;
         k_reg       <= k_next;
         tag_row_reg <= tag_row_next;
         tag_col_reg <= tag_col_next;
         // Aligns the tags with the ROM data, which arrives one cycle after the address.
         out_en_reg  <= rom_en;
         out_row_reg <= rom_en ? tag_row_reg : '0;
         out_col_reg <= rom_en ? tag_col_reg : '0;
         out_cls_reg <= rom_addr;
      end
   end

   assign out_en  = out_en_reg;
   assign out_row = out_row_reg;
   assign out_col = out_col_reg;
   assign out_cls = out_cls_reg;

endmodule

// File: doc/dcout_seq.md
Name: dcout_seq

Overview:
- Sequencer for the binary-convolutional decoder output stage (final classifier layer).
- Streams one padded feature-map frame, in raster order, into the input window shift register, inserting zero padding itself.
- Stalls the input while the shared PE sweeps all FD class filters through the weight/norm-ref ROMs.
- Emits one tagged out_en strobe per class score and a done pulse at frame end.

Parameters:
- H, 32, unpadded input rows.
- W, 128, unpadded input columns.
- FH, 3, filter height.
- FW, 3, filter width.
- PAD, 1, zero border width. FH=FW=2*PAD+1 is required, so output is H x W.
- FD, 512, number of output classes (ROM depth).
- ADDR_W, $clog2(FD) (min 1), ROM address width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset. Asynchronous, active-low. All state is cleared while rst=0.
- start  in  1  one-cycle frame start. Honoured only in IDLE.
- in_en  in  1  upstream pixel valid. A pixel is consumed when in_en && in_ready.
- in_ready  out  1  sequencer accepts a pixel this cycle.
- sr_en  out  1  shift-register advance.
- pad_sel  out  1  zero-mux select: 1 means shift zeros instead of data_in.
- rom_en  out  1  weight/norm-ref/scale ROM read enable.
- rom_addr  out  ADDR_W  ROM class address.
- out_en  out  1  PE output valid (score for out_row/out_col/out_cls).
- out_row  out  $clog2(H)  output pixel row tag.
- out_col  out  $clog2(W)  output pixel column tag.
- out_cls  out  ADDR_W  class tag.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle end-of-frame pulse.

Behaviour:
- Padded frame: Hp=H+2*PAD rows, Wp=W+2*PAD columns. Position counters r in 0..Hp-1 and c in 0..Wp-1 wrap in raster order.
- A position is pad when r<PAD, r>=H+PAD, c<PAD or c>=W+PAD.
- States: IDLE, FEED, COMPUTE, FLUSH, DONE.
- IDLE:
  - All outputs 0.
  - start moves to FEED next cycle with r=c=0.
- FEED, pad position: sr_en=1, pad_sel=1, in_ready=0. The shift happens this cycle.
- FEED, interior position: in_ready=1, sr_en=in_en, pad_sel=0. If in_en=0, hold position (stall) with no shift.
- When a shift occurs at (r,c):
  - If r>=FH-1 and c>=FW-1, go to COMPUTE with k=0 and the tag latched as row=r-(FH-1), col=c-(FW-1).
  - Otherwise advance the position and stay in FEED.
- COMPUTE:
  - rom_en=1, rom_addr=k, in_ready=0, sr_en=0. k increments every cycle.
  - At k=FD-1: if (r,c)=(Hp-1,Wp-1) go to FLUSH; otherwise advance the position and go to FEED.
- ROM read latency is 1 cycle; the PE is combinational.
  - out_en is registered: it equals rom_en delayed by 1 cycle.
  - out_cls equals rom_addr delayed by 1 cycle; out_row/out_col are the delayed pixel tag.
  - out_en may therefore be high during the first FEED cycle after COMPUTE.
- FLUSH: one cycle in which the final out_en appears, then DONE.
- DONE: done=1 for one cycle, then IDLE.
- Output ordering and totals:
  - Exactly H*W*FD out_en strobes per frame.
  - Tags strictly raster-then-class ordered, with no gaps or duplicates.
- start while busy is ignored. in_en outside FEED-interior is ignored, with no consumption.
- rst=0 at any time: immediate return to IDLE; all outputs, counters and the out_en pipeline stage go to 0. No partial done.
- Minimum frame latency with in_en held high: start cycle + Hp*Wp FEED cycles + H*W*FD COMPUTE cycles + FLUSH + DONE.

Test Plan:
- Parameters H=2, W=3, FH=FW=3, PAD=1, FD=4 (Hp=4, Wp=5). start at cycle 0, in_en=1 always:
  - in_ready high 6 cycles, 20 sr_en pulses, pad_sel high on 14 of them.
  - First COMPUTE at cycle 14; first out_en at cycle 15 with row 0, col 0, cls 0.
  - 24 out_en strobes total; last at cycle 45 (row 1, col 2, cls 3); done at cycle 46; busy low at 47.
- Same setup with in_en low for 3 cycles at interior position (2,3): no sr_en during the stall; done moves to cycle 49; tag order unchanged.
- start pulsed again at cycle 20 mid-frame: ignored; exactly 24 strobes and one done.
- rst driven low at cycle 30 then released: all outputs 0 during reset; IDLE afterwards. A new start gives a full clean frame with done 46 cycles later.
- in_en=1 during COMPUTE and on pad positions: in_ready=0 and no consumption; total consumed pixels = 6.
- FD=1 corner: COMPUTE lasts one cycle per pixel; 6 strobes, all with cls=0; done at cycle 28.
